ad_frame_writer: RTL and testbench

//  Drains the AD-to-RAM FIFO (AD7606 samples, 8 channels per conversion) and writes them into
//  a ping-pong dual-bank sample RAM, one frame per bank. Arms on start, stops at a frame boundary.

---
 rtl/ad_frame_writer.sv | 148 ++++++++++++++
 tb/tb_ad_frame_writer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad_frame_writer.sv
// Drains the AD sample FIFO into a ping-pong two-bank sample RAM, one frame per bank,
// and hands each completed bank to the downstream filter until it is released.
module ad_frame_writer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 512,
    parameter int CH_NUM    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [2:0]        ram_ch,
    output logic              frame_done,
    output logic              frame_bank,
    input  logic [1:0]        bank_release,
    output logic [1:0]        bank_full,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BANK,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  rd_cnt_reg;
    logic [ADDR_W-1:0] wr_cnt_reg;
    logic              cur_bank_reg;
    logic              stop_pend_reg;
    logic              wr_pend_reg;
    logic              overrun_reg;
    logic              frame_bank_reg;
    logic [1:0]        bank_full_reg;
    logic              rd_req;

    // Next-state and read-request decode
    always_comb begin
        state_next = state_reg;
        rd_req     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_WAIT_BANK;
            end
            S_WAIT_BANK: begin
                // Wait for the same bank to be returned so frame order stays alternating
                if (stop)
                    state_next = S_IDLE;
                else if (!bank_full_reg[cur_bank_reg])
                    state_next = S_READ;
            end
            S_READ: begin
                rd_req = !fifo_empty && (rd_cnt_reg < CNT_W'(FRAME_LEN));
                if (rd_req && rd_cnt_reg == CNT_W'(FRAME_LEN - 1))
                    state_next = S_FLUSH;
            end
            S_FLUSH: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = (stop_pend_reg || stop) ? S_IDLE : S_WAIT_BANK;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            rd_cnt_reg     <= '0;
            wr_cnt_reg     <= '0;
            cur_bank_reg   <= 1'b0;
            stop_pend_reg  <= 1'b0;
            wr_pend_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_bank_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_pend_reg <= rd_req;

            if (state_reg == S_WAIT_BANK && state_next == S_READ) begin
                rd_cnt_reg <= '0;
                wr_cnt_reg <= '0;
            end else begin
                if (rd_req)      rd_cnt_reg <= rd_cnt_reg + 1'b1;
                if (wr_pend_reg) wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end

            // start in IDLE re-arms; a simultaneous stop still limits capture to one frame
            if (state_reg == S_IDLE) begin
                if (start) stop_pend_reg <= stop;
            end else if (stop) begin
                stop_pend_reg <= 1'b1;
            end

            if (state_reg == S_IDLE && start)
                overrun_reg <= 1'b0;
            else if (state_reg != S_IDLE && fifo_full)
                overrun_reg <= 1'b1;

            if (state_reg == S_DONE) begin
                frame_bank_reg <= cur_bank_reg;
                cur_bank_reg   <= ~cur_bank_reg;
            end
        end
    end

    // Per-bank ownership: handing a bank over beats a same-cycle release
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (reset)
                    bank_full_reg[gi] <= 1'b0;
                else if (state_reg == S_DONE && cur_bank_reg == 1'(gi))
                    bank_full_reg[gi] <= 1'b1;
                else if (bank_release[gi])
                    bank_full_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    assign fifo_rdreq = rd_req;
    assign ram_we     = wr_pend_reg;
    assign ram_addr   = wr_pend_reg ? {cur_bank_reg, wr_cnt_reg} : '0;
    assign ram_wdata  = wr_pend_reg ? fifo_q : '0;
    assign ram_ch     = wr_pend_reg ? 3'(wr_cnt_reg % ADDR_W'(CH_NUM)) : 3'd0;
    assign frame_done = (state_reg == S_DONE);
    assign frame_bank = frame_bank_reg;
    assign bank_full  = bank_full_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ad_frame_writer.sv
// Scoreboard bench for ad_frame_writer: a queue-based FIFO model feeds frames and every
// RAM write and frame handoff is compared against expectations queued with the stimulus.
module tb_ad_frame_writer;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 10;
    localparam int FRAME_LEN = 512;
    localparam int CH_NUM    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              fifo_empty = 1'b1;
    logic              fifo_full = 1'b0;
    logic [DATA_W-1:0] fifo_q = '0;
    logic              fifo_rdreq;
    logic              ram_we;
    logic [ADDR_W:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [2:0]        ram_ch;
    logic              frame_done;
    logic              frame_bank;
    logic [1:0]        bank_release = 2'b00;
    logic [1:0]        bank_full;
    logic              overrun;
    logic              busy;

    always #5 clk = ~clk;

    ad_frame_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN), .CH_NUM(CH_NUM)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_q(fifo_q),
        .fifo_rdreq(fifo_rdreq), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_ch(ram_ch), .frame_done(frame_done),
        .frame_bank(frame_bank), .bank_release(bank_release), .bank_full(bank_full),
        .overrun(overrun), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int done_seen = 0;

    logic [DATA_W-1:0] fifo_mem[$];
    logic [29:0]       exp_q[$];
    logic              exp_bank_q[$];
    logic              gap_en = 1'b0;
    logic              gap_ph = 1'b0;
    logic              pop_now;
    logic              bank_chk_pend = 1'b0;
    logic              exp_fb;
    logic [29:0]       exp_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // FIFO read side: data appears the cycle after a request; optional every-other-cycle empty
    always @(posedge clk) begin
        pop_now = fifo_rdreq;
        #1;
        if (pop_now && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
        gap_ph = ~gap_ph;
        fifo_empty = (fifo_mem.size() == 0) || (gap_en && gap_ph);
    end

    // Output monitor
    always @(negedge clk) begin
        if (bank_chk_pend) begin
            check("frame_bank", 32'(frame_bank), 32'(exp_fb));
            $display("frame %0d handed over bank %0d bank_full=%b", done_seen, frame_bank, bank_full);
            bank_chk_pend = 1'b0;
        end
        if (fifo_rdreq) check("rdreq_while_empty", 32'(fifo_empty), 32'd0);
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(ram_we), 32'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("ram_write", 32'({ram_addr, ram_wdata, ram_ch}), 32'(exp_w));
            end
            wr_seen++;
        end
        if (frame_done) begin
            done_seen++;
            if (exp_bank_q.size() == 0) begin
                check("unexpected_done", 32'(frame_done), 32'd0);
            end else begin
                exp_fb = exp_bank_q.pop_front();
                bank_chk_pend = 1'b1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic pulse_release(input logic [1:0] v);
        @(posedge clk); #1 bank_release = v;
        @(posedge clk); #1 bank_release = 2'b00;
    endtask

    task automatic push_frame(input logic bank, input int n, input int base, input logic full);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            fifo_mem.push_back(DATA_W'(base + i));
            exp_q.push_back({bank, ADDR_W'(i), DATA_W'(base + i), 3'(i % CH_NUM)});
        end
        if (full) exp_bank_q.push_back(bank);
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 5000 && wr_seen < n; i++) @(posedge clk);
        check("wait_writes", 32'(wr_seen), 32'(n));
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 5000 && done_seen < n; i++) @(posedge clk);
        check("wait_frame_done", 32'(done_seen), 32'(n));
    endtask

    initial begin
        // Reset state
        cycles(3);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_bank_full", 32'(bank_full), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // Frame 1: bank 0, data == address
        push_frame(1'b0, FRAME_LEN, 0, 1'b1);
        pulse_start();
        wait_done(1);
        cycles(2);
        @(negedge clk) check("bank_full_f1", 32'(bank_full), 32'b01);

        // Frame 2: bank 1, then block on bank 0 still owned
        push_frame(1'b1, FRAME_LEN, 16'h1000, 1'b1);
        wait_done(2);
        cycles(2);
        @(negedge clk) check("bank_full_f2", 32'(bank_full), 32'b11);

        gap_en = 1'b1;
        push_frame(1'b0, FRAME_LEN, 16'h2000, 1'b1);
        cycles(20);
        @(negedge clk);
        check("blocked_rdreq", 32'(fifo_rdreq), 32'd0);
        check("blocked_busy", 32'(busy), 32'd1);
        check("blocked_writes", 32'(wr_seen), 32'(2 * FRAME_LEN));

        // Frame 3: bank 0 after release, FIFO empty every other cycle
        pulse_release(2'b11);
        wait_done(3);
        gap_en = 1'b0;
        cycles(2);
        @(negedge clk) check("bank_full_f3", 32'(bank_full), 32'b01);

        // Frame 4: bank 1, overrun blip, stop at sample 100
        push_frame(1'b1, FRAME_LEN, 16'h3000, 1'b1);
        wait_writes(3 * FRAME_LEN + 50);
        @(posedge clk); #1 fifo_full = 1'b1;
        @(posedge clk); #1 fifo_full = 1'b0;
        @(negedge clk) check("overrun_set", 32'(overrun), 32'd1);
        wait_writes(3 * FRAME_LEN + 100);
        pulse_stop();
        wait_done(4);
        cycles(3);
        @(negedge clk);
        check("stopped_busy", 32'(busy), 32'd0);
        check("stopped_rdreq", 32'(fifo_rdreq), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("bank_full_f4", 32'(bank_full), 32'b11);
        check("writes_f4", 32'(wr_seen), 32'(4 * FRAME_LEN));
        pulse_release(2'b11);
        @(negedge clk) check("bank_full_released", 32'(bank_full), 32'b00);

        // Frame 5: start clears overrun, then reset mid-frame
        pulse_start();
        @(negedge clk);
        check("overrun_cleared", 32'(overrun), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        push_frame(1'b0, 300, 16'h4000, 1'b0);
        wait_writes(4 * FRAME_LEN + 300);
        @(posedge clk); #1 fifo_full = 1'b1;
        @(posedge clk); #1 fifo_full = 1'b0;
        @(negedge clk) check("overrun_f5", 32'(overrun), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        check("abort_bank_full", 32'(bank_full), 32'd0);
        check("abort_frame_bank", 32'(frame_bank), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_done_count", 32'(done_seen), 32'd4);

        // Frame 6: start+stop together -> one frame in bank 0, then idle
        push_frame(1'b0, FRAME_LEN, 16'h5000, 1'b1);
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        wait_done(5);
        cycles(3);
        @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        check("final_bank_full", 32'(bank_full), 32'b01);
        check("final_exp_left", 32'(exp_q.size()), 32'd0);
        check("final_fifo_left", 32'(fifo_mem.size()), 32'd0);
        check("final_writes", 32'(wr_seen), 32'(5 * FRAME_LEN + 300));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
